// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and constants for the MIPS core's bus-side units.
package mips_bus_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} mem_size_t;
   localparam int ERR_MISALIGN = 0;
   localparam int ERR_TIMEOUT = 1;
endpackage

// File: rtl/lsu_lane_extract.sv
// lsu_lane_extract: pulls a byte/half/word/dword out of a bus beat and sign- or zero-extends it.
module lsu_lane_extract
   import mips_bus_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]           data,
   input  logic [$clog2(DATA_W/8)-1:0] off,
   input  mem_size_t                   size,
   input  logic                        sgn,
   output logic [DATA_W-1:0]           result
);
   logic [DATA_W-1:0] sh, mask;
   logic [7:0] nb;
   // mask & ~(mask >> 1) isolates the top bit of the selected field, giving its sign bit
   always_comb begin
      sh = data >> {off, 3'b000};
      nb = 8'd8 << size;
      mask = nb >= 8'(DATA_W) ? '1 : ~({DATA_W{1'b1}} << nb);
      result = (sh & mask) | ((sgn && |(sh & mask & ~(mask >> 1))) ? ~mask : '0);
   end
endmodule

// File: rtl/mips_avalon_lsu.sv
// mips_avalon_lsu: single-outstanding load/store unit bridging the MIPS core to an Avalon-MM master.
module mips_avalon_lsu
   import mips_bus_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [1:0]          req_size,
   input  logic                req_signed,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic [1:0]          resp_err,
   output logic [ADDR_W-1:0]   address,
   output logic                read,
   output logic                write,
   input  logic                waitrequest,
   output logic [DATA_W-1:0]   writedata,
   output logic [DATA_W/8-1:0] byteenable,
   input  logic [DATA_W-1:0]   readdata
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

   lsu_state_t state, nxt;
   mem_size_t size_q;
   logic wr_q, sgn_q, accept, mis, done, tmo;
   logic [OFF_W-1:0] off_q;
   logic [CNT_W-1:0] cnt;
   logic [2:0] lm;
   logic [7:0] sm;
   logic [BYTES-1:0] be_n;
   logic [DATA_W-1:0] wd_n, ext;

   assign req_ready = state == IDLE && reset;
   assign resp_valid = state == RESP;
   assign read = state == ACCESS && !wr_q;
   assign write = state == ACCESS && wr_q;

   always_comb begin
      lm = 3'((4'b1 << req_size) - 4'd1);
      mis = (mem_size_t'(req_size) == SZ_DWORD && DATA_W == 32) || |(req_addr[2:0] & lm);
      accept = req_valid && req_ready;
      done = state == ACCESS && !waitrequest;
      tmo = state == ACCESS && waitrequest && TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT);
      nxt = state == IDLE ? (accept ? (mis ? RESP : ACCESS) : IDLE)
          : state == ACCESS ? ((done || tmo) ? RESP : ACCESS) : IDLE;
      sm = req_size == 2'd0 ? 8'h01 : req_size == 2'd1 ? 8'h03 : req_size == 2'd2 ? 8'h0F : 8'hFF;
      be_n = BYTES'(sm) << req_addr[OFF_W-1:0];
      // replicate across every lane so whichever lanes are enabled carry the data
      wd_n = req_size == 2'd0 ? {BYTES{req_wdata[7:0]}}
           : req_size == 2'd1 ? {(BYTES/2){req_wdata[15:0]}}
           : req_size == 2'd2 ? {(DATA_W/32){req_wdata[31:0]}} : req_wdata;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= nxt;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         size_q <= SZ_BYTE;
         wr_q <= 1'b0;
         sgn_q <= 1'b0;
         off_q <= '0;
         cnt <= '0;
         address <= '0;
         writedata <= '0;
         byteenable <= '0;
         resp_rdata <= '0;
         resp_err <= '0;
      end else begin
         if (state == ACCESS && waitrequest) cnt <= cnt + 1'b1;
         if (accept) begin
            wr_q <= req_write;
            size_q <= mem_size_t'(req_size);
            sgn_q <= req_signed;
            off_q <= req_addr[OFF_W-1:0];
            cnt <= '0;
            resp_rdata <= '0;
            resp_err <= '0;
            resp_err[ERR_MISALIGN] <= mis;
            if (!mis) begin
               address <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               writedata <= wd_n;
               byteenable <= be_n;
            end
         end
         if (done) resp_rdata <= wr_q ? '0 : ext;
         if (tmo) resp_err[ERR_TIMEOUT] <= 1'b1;
      end

   lsu_lane_extract #(.DATA_W(DATA_W)) u_ext (
      .data(readdata),
      .off(off_q),
      .size(size_q),
      .sgn(sgn_q),
      .result(ext)
   );
endmodule
